// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: Whac-A-Mole round sequencer.
// Runs ROUNDS rounds; each lights one LFSR-chosen mole after a dark gap and
// waits for its switch or a difficulty-dependent timeout.
// Optional build macro: MISS_PENALTY_EN (wrong switches and timeouts cost a point).
module mole_game_ctrl #(
  parameter int CLKS_PER_MS = 50000,
  parameter int NUM_MOLES   = 8,
  parameter int ROUNDS      = 20,
  parameter int GAP_MS      = 500,
  parameter int TMO_EASY_MS = 1500,
  parameter int TMO_MED_MS  = 1000,
  parameter int TMO_HARD_MS = 600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_btn,
  input  logic [1:0]           diff_sel,
  input  logic [NUM_MOLES-1:0] sw,
  output logic [NUM_MOLES-1:0] mole_led,
  output logic                 start_evt,
  output logic                 stop_evt,
  output logic [15:0]          score,
  output logic [2:0]           diff,
  output logic                 game_over
);

  localparam int IDX_W = $clog2(NUM_MOLES);
  localparam int PRE_W = $clog2(CLKS_PER_MS + 1);
  localparam int RND_W = $clog2(ROUNDS + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GAP  = 2'd1;
  localparam logic [1:0] ST_UP   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [15:0] SCORE_MAX = 16'd9999;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [1:0]           state_r;
  logic [1:0]           state_nxt_s;
  logic [15:0]          lfsr_r;
  logic [NUM_MOLES-1:0] sw_q_r;
  logic [NUM_MOLES-1:0] hit_vec_s;
  logic [NUM_MOLES-1:0] mole_mask_s;
  logic [IDX_W-1:0]     idx_r;
  logic [PRE_W-1:0]     pre_r;
  logic [15:0]          ms_r;
  logic [15:0]          tmo_last_s;
  logic [RND_W-1:0]     rounds_r;
  logic                 ms_last_s;
  logic                 gap_done_s;
  logic                 tmo_s;
  logic                 correct_s;
  logic                 last_round_s;
`ifdef MISS_PENALTY_EN
  logic                 wrong_s;
`endif

  // Fibonacci LFSR step, taps 16,14,13,11; a nonzero seed never reaches 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Score increment that holds at the display limit.
  function automatic logic [15:0] score_inc(input logic [15:0] s);
    return (s >= SCORE_MAX) ? SCORE_MAX : s + 16'd1;
  endfunction

`ifdef MISS_PENALTY_EN
  // Score decrement floored at zero.
  function automatic logic [15:0] score_dec(input logic [15:0] s);
    return (s == 16'd0) ? 16'd0 : s - 16'd1;
  endfunction
`endif

  // Decode switch rising edges, ms-tick boundaries and the active timeout.
  always_comb begin
    hit_vec_s   = sw & ~sw_q_r;
    mole_mask_s = {{(NUM_MOLES-1){1'b0}}, 1'b1} << idx_r;
    correct_s   = |(hit_vec_s & mole_mask_s);
`ifdef MISS_PENALTY_EN
    wrong_s     = |(hit_vec_s & ~mole_mask_s);
`endif
    ms_last_s   = (pre_r == PRE_W'(CLKS_PER_MS - 1));
    if (diff[2]) begin
      tmo_last_s = 16'(TMO_HARD_MS - 1);
    end else if (diff[1]) begin
      tmo_last_s = 16'(TMO_MED_MS - 1);
    end else begin
      tmo_last_s = 16'(TMO_EASY_MS - 1);
    end
    gap_done_s   = ms_last_s && (ms_r == 16'(GAP_MS - 1));
    tmo_s        = ms_last_s && (ms_r == tmo_last_s);
    last_round_s = (rounds_r == RND_W'(ROUNDS - 1));
  end

  // Next-state selection for the round sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_btn) state_nxt_s = ST_GAP;
        else           state_nxt_s = state_r;
      end
      ST_GAP: begin
        if (gap_done_s) state_nxt_s = ST_UP;
        else            state_nxt_s = state_r;
      end
      ST_UP: begin
        if (correct_s || tmo_s) state_nxt_s = last_round_s ? ST_DONE : ST_GAP;
        else                    state_nxt_s = state_r;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // ms timebase; restarts on every state entry so phase lengths are exact.
  always_ff @(posedge clk) begin
    if (rst || (state_nxt_s != state_r)) begin
      pre_r <= {PRE_W{1'b0}};
      ms_r  <= 16'd0;
    end else if (ms_last_s) begin
      pre_r <= {PRE_W{1'b0}};
      ms_r  <= ms_r + 16'd1;
    end else begin
      pre_r <= pre_r + PRE_W'(1);
    end
  end

  // Game state, LFSR, switch history and all registered outputs.
  always_ff @(posedge clk) begin
    sw_q_r    <= sw;
    lfsr_r    <= lfsr_next(lfsr_r);
    start_evt <= 1'b0;
    stop_evt  <= 1'b0;
    if (rst) begin
      state_r   <= ST_IDLE;
      lfsr_r    <= LFSR_SEED;
      idx_r     <= {IDX_W{1'b0}};
      rounds_r  <= {RND_W{1'b0}};
      mole_led  <= {NUM_MOLES{1'b0}};
      score     <= 16'd0;
      diff      <= 3'b001;
      game_over <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_btn) begin
            score     <= 16'd0;
            rounds_r  <= {RND_W{1'b0}};
            game_over <= 1'b0;
            mole_led  <= {NUM_MOLES{1'b0}};
            case (diff_sel)
              2'b10:   diff <= 3'b010;
              2'b11:   diff <= 3'b100;
              default: diff <= 3'b001;
            endcase
          end
        end
        ST_GAP: begin
          if (gap_done_s) begin
            idx_r     <= lfsr_r[IDX_W-1:0];
            mole_led  <= {{(NUM_MOLES-1){1'b0}}, 1'b1} << lfsr_r[IDX_W-1:0];
            start_evt <= 1'b1;
          end
        end
        ST_UP: begin
          // A correct hit outranks both a timeout and stray switches.
          if (correct_s) begin
            stop_evt <= 1'b1;
            score    <= score_inc(score);
          end
`ifdef MISS_PENALTY_EN
          else if (tmo_s || wrong_s) begin
            score <= score_dec(score);
          end
`endif
          if (correct_s || tmo_s) begin
            mole_led  <= {NUM_MOLES{1'b0}};
            rounds_r  <= rounds_r + RND_W'(1);
            game_over <= last_round_s;
          end
        end
        default: begin
          mole_led <= {NUM_MOLES{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Randomized bench for mole_game_ctrl with a cycle-level reference model
// built from the game rules (phase countdowns, polynomial LFSR, score arithmetic).
`timescale 1ns/1ps
module tb_mole_game_ctrl;

  localparam int CPM  = 5;
  localparam int NM   = 8;
  localparam int RNDS = 3;
  localparam int GAPM = 2;
  localparam int TE   = 10;
  localparam int TM   = 6;
  localparam int TH   = 3;
  localparam int GAP_CYC   = GAPM * CPM;
  localparam int SCORE_CAP = 9999;
  localparam int SAT_RNDS  = 10001;

  localparam int P_IDLE = 0;
  localparam int P_GAP  = 1;
  localparam int P_UP   = 2;
  localparam int P_DONE = 3;

`ifdef MISS_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start_btn;
  logic [1:0]    diff_sel;
  logic [NM-1:0] sw, mole_led;
  logic          start_evt, stop_evt, game_over;
  logic [15:0]   score;
  logic [2:0]    diff;

  logic          rst2, start2;
  logic [1:0]    dsel2;
  logic [NM-1:0] sw2, mole2;
  logic          sevt2, pevt2, go2;
  logic [15:0]   score2;
  logic [2:0]    diff2;

  mole_game_ctrl #(.CLKS_PER_MS(CPM), .NUM_MOLES(NM), .ROUNDS(RNDS), .GAP_MS(GAPM),
                   .TMO_EASY_MS(TE), .TMO_MED_MS(TM), .TMO_HARD_MS(TH)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .diff_sel(diff_sel), .sw(sw),
    .mole_led(mole_led), .start_evt(start_evt), .stop_evt(stop_evt),
    .score(score), .diff(diff), .game_over(game_over));

  mole_game_ctrl #(.CLKS_PER_MS(1), .NUM_MOLES(NM), .ROUNDS(SAT_RNDS), .GAP_MS(1),
                   .TMO_EASY_MS(4), .TMO_MED_MS(4), .TMO_HARD_MS(4)) dut_sat (
    .clk(clk), .rst(rst2), .start_btn(start2), .diff_sel(dsel2), .sw(sw2),
    .mole_led(mole2), .start_evt(sevt2), .stop_evt(pevt2),
    .score(score2), .diff(diff2), .game_over(go2));

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int            m_ph, m_left, m_idx, m_round, m_score, m_diff, m_tmo;
  logic [15:0]   m_lfsr;
  logic [NM-1:0] m_swq, e_mole;
  logic          e_start, e_stop;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int tmo_cycles(input logic [1:0] ds);
    if (ds == 2'b11) return TH * CPM;
    if (ds == 2'b10) return TM * CPM;
    return TE * CPM;
  endfunction

  function automatic void end_round();
    e_mole  = '0;
    m_round = m_round + 1;
    m_ph    = (m_round == RNDS) ? P_DONE : P_GAP;
    m_left  = GAP_CYC;
  endfunction

  // Advance the reference model by one clock edge using the inputs at that edge.
  function automatic void model_step();
    logic [NM-1:0] rise;
    logic [15:0]   prev;
    if (rst) begin
      m_ph = P_IDLE; m_score = 0; m_diff = 1; m_round = 0;
      m_lfsr = 16'hACE1; m_swq = sw; e_mole = '0; e_start = 1'b0; e_stop = 1'b0;
      return;
    end
    rise   = sw & ~m_swq;
    m_swq  = sw;
    prev   = m_lfsr;
    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    e_start = 1'b0;
    e_stop  = 1'b0;
    case (m_ph)
      P_IDLE, P_DONE: begin
        if (start_btn) begin
          m_ph = P_GAP; m_left = GAP_CYC; m_score = 0; m_round = 0; e_mole = '0;
          m_diff = (diff_sel == 2'b11) ? 4 : (diff_sel == 2'b10) ? 2 : 1;
          m_tmo  = tmo_cycles(diff_sel);
        end
      end
      P_GAP: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_idx = int'(prev) % NM;
          m_ph = P_UP; m_left = m_tmo;
          e_mole = '0; e_mole[m_idx] = 1'b1; e_start = 1'b1;
        end
      end
      default: begin
        m_left = m_left - 1;
        if (rise[m_idx]) begin
          m_score = (m_score + 1 > SCORE_CAP) ? SCORE_CAP : m_score + 1;
          e_stop = 1'b1;
          end_round();
        end else if (m_left == 0) begin
          if (PEN && m_score > 0) m_score = m_score - 1;
          end_round();
        end else if (PEN && rise != '0 && m_score > 0) begin
          m_score = m_score - 1;
        end
      end
    endcase
  endfunction

  // One clock: step the model on the edge, then compare every output.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_val("mole_led", 32'(mole_led), 32'(e_mole));
    check_val("start_evt", 32'(start_evt), 32'(e_start));
    check_val("stop_evt", 32'(stop_evt), 32'(e_stop));
    check_val("score", 32'(score), 32'(m_score));
    check_val("diff", 32'(diff), 32'(m_diff));
    check_val("game_over", 32'(game_over), 32'(m_ph == P_DONE));
  endtask

  task automatic start_game(input logic [1:0] ds);
    diff_sel  = ds;
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    diff_sel  = 2'($urandom);
  endtask

  // Wait out the gap, then press the mole switch at cycle d (wrong switch at wrong_at).
  task automatic play_round(input int d, input int wrong_at, output int gap_seen, output int clear_at);
    int t;
    logic [NM-1:0] v;
    gap_seen = -1;
    clear_at = -1;
    t = 0;
    while (!e_start && t < 200) begin
      start_btn = ($urandom_range(0, 5) == 0) && (m_ph == P_GAP);
      tick();
      t++;
      start_btn = 1'b0;
      if (start_evt === 1'b1 && gap_seen < 0) gap_seen = t;
    end
    if (!e_start) check_val("round_start", 32'(start_evt), 32'd1);
    for (int k = 1; k <= 120 && e_mole != '0; k++) begin
      v = '0;
      if (k == d) v[m_idx] = 1'b1;
      if (k == wrong_at) v[(m_idx + int'($urandom_range(1, NM - 1))) % NM] = 1'b1;
      if ($urandom_range(0, 9) == 0) diff_sel = 2'($urandom);
      start_btn = ($urandom_range(0, 9) == 0);
      sw = v;
      tick();
      start_btn = 1'b0;
      if (clear_at < 0 && mole_led === '0) clear_at = k;
    end
    sw = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, g, c, w, hits, tmo;
    logic [1:0] ds;
    rst = 1'b1; start_btn = 1'b0; diff_sel = 2'b00; sw = 8'hFF;
    rst2 = 1'b1; start2 = 1'b0; dsel2 = 2'b00; sw2 = '0;

    // reset with all switches held, then release them: no edge, no score change
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    sw = '0;
    repeat (2) tick();
    check_val("idle_score", 32'(score), 32'd0);

    // game A: medium, start_evt latency, random rounds
    start_game(2'b10);
    check_val("diff_med", 32'(diff), 32'b010);
    lat = 0;
    while (start_evt !== 1'b1 && lat < 40) begin tick(); lat++; end
    check_val("start_lat", 32'(lat), 32'd10);
    for (int r = 0; r < RNDS; r++)
      play_round($urandom_range(1, 35), $urandom_range(0, 35), g, c);

    // game B: easy, hit 37 cycles after start_evt, next mole 10 cycles after the hit
    start_game(2'b00);
    play_round(37, 0, g, c);
    check_val("hit37_clear", 32'(c), 32'd37);
    check_val("hit37_score", 32'(score), 32'd1);
    play_round(5, 3, g, c);
    check_val("gap_after_hit", 32'(g), 32'd10);
    play_round($urandom_range(1, 55), 0, g, c);

    // game C: hard, never hit
    start_game(2'b11);
    for (int r = 0; r < RNDS; r++) begin
      play_round(1000, 0, g, c);
      check_val("hard_tmo", 32'(c), 32'd15);
    end
    check_val("hard_over", 32'(game_over), 32'd1);
    check_val("hard_score", 32'(score), 32'd0);

    // game D: restart from DONE, hit on the timeout cycle counts as a hit
    start_game(2'b01);
    play_round(TE * CPM, 0, g, c);
    check_val("hit_at_tmo", 32'(score), 32'd1);
    play_round(TE * CPM + 1, 0, g, c);
    play_round(1, 1, g, c);

    // reset in the middle of a lit mole
    start_game(2'b10);
    w = 0;
    while (!e_start && w < 40) begin tick(); w++; end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst_mole", 32'(mole_led), 32'd0);
    check_val("rst_diff", 32'(diff), 32'b001);
    tick();

    // random games
    for (int gi = 0; gi < 6; gi++) begin
      ds = 2'($urandom);
      tmo = tmo_cycles(ds);
      start_game(ds);
      for (int r = 0; r < RNDS; r++)
        play_round($urandom_range(1, tmo + 6), $urandom_range(0, tmo), g, c);
      repeat ($urandom_range(0, 4)) tick();
    end

    // saturation: second instance, every mole hit on its first cycle
    @(negedge clk); @(negedge clk);
    rst2 = 1'b0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    hits = 0;
    for (int r = 0; r < SAT_RNDS; r++) begin
      w = 0;
      while (mole2 === '0 && w < 20) begin @(negedge clk); w++; end
      if (mole2 === '0) begin
        check_val("sat_mole", 32'(mole2), 32'd1);
        break;
      end
      sw2 = mole2;
      @(negedge clk);
      sw2 = '0;
      hits++;
      if (hits <= 2 || hits >= 9997)
        check_val("sat_score", 32'(score2), 32'((hits > SCORE_CAP) ? SCORE_CAP : hits));
    end
    @(negedge clk);
    check_val("sat_over", 32'(go2), 32'd1);
    check_val("sat_final", 32'(score2), 32'd9999);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
